extrinsic_llr_pipe: RTL and testbench

- Downstream stage of the epsilon pipe in the fully parallel turbo decoder's per-bit algorithmic block.
- Consumes the four registered epsilon maxima plus the bit's a-priori and systematic LLRs.
- Produces a scaled, saturated extrinsic LLR for the other component decoder, a hard decision, and a per-bit hard-decision stability count for early termination.
- Two-stage pipeline with valid tracking; frame-level clear.

---
 rtl/extrinsic_llr_pipe.sv | 124 ++++++++++++
 tb/tb_extrinsic_llr_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/extrinsic_llr_pipe.sv
// Extrinsic LLR stage of the turbo decoder's per-bit block: max-selects the epsilon groups,
// scales and saturates the extrinsic LLR, and tracks hard-decision stability for early termination.
module extrinsic_llr_pipe #(
  parameter int M      = 6,
  parameter int C      = 4,
  parameter int THRESH = 3
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   frame_start,
  input  logic                   in_valid,
  input  logic signed [4:1][M:0] epsilon,
  input  logic signed [M-1:0]    apriori,
  input  logic signed [M-1:0]    systematic,
  output logic                   ext_valid,
  output logic signed [M-1:0]    extrinsic,
  output logic                   hard_bit,
  output logic [C-1:0]           stable_count,
  output logic                   converged
);

  // Widest intermediate (e, s, post) is M+3 bits, enough for d - apriori and d + systematic.
  localparam int W = M + 3;
  localparam logic signed [W-1:0] SAT_POS = W'((2 ** (M - 1)) - 1);
  localparam logic signed [W-1:0] SAT_NEG = -SAT_POS;
  localparam logic [C-1:0]        COUNT_MAX = '1;
  localparam logic [C-1:0]        THRESH_C  = C'(THRESH);

  typedef struct packed {
    logic signed [M:0]   m1;
    logic signed [M:0]   m0;
    logic signed [M-1:0] apriori;
    logic signed [M-1:0] systematic;
  } stage1_t;

  stage1_t             s1_d, s1_q;
  logic                v1;
  logic                have_prev;

  logic signed [M+1:0] d;
  logic signed [W-1:0] e;
  logic signed [W-1:0] s;
  logic signed [W-1:0] post;
  logic signed [M-1:0] ext_d;
  logic                hard_d;
  logic [C-1:0]        stable_next;
  logic                conv_next;

  // Stage 1 combinational: group maxima. Packed-array selects are unsigned, hence the casts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s1_d            = '0;
    s1_d.m1         = ($signed(epsilon[1]) > $signed(epsilon[2])) ? epsilon[1] : epsilon[2];
    s1_d.m0         = ($signed(epsilon[3]) > $signed(epsilon[4])) ? epsilon[3] : epsilon[4];
    s1_d.apriori    = apriori;
    s1_d.systematic = systematic;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else begin
      // A sample arriving with frame_start is the first of the new frame, so it is kept.
      v1 <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2 combinational: difference, 0.75 scaling by floor shift, symmetric saturation.
  always_comb begin
    d      = $signed({s1_q.m1[M], s1_q.m1}) - $signed({s1_q.m0[M], s1_q.m0});
    e      = $signed({d[M+1], d}) - $signed({{3{s1_q.apriori[M-1]}}, s1_q.apriori});
    s      = e - (e >>> 2);
    post   = $signed({d[M+1], d}) + $signed({{3{s1_q.systematic[M-1]}}, s1_q.systematic});
    hard_d = !post[W-1] && (post != '0);
    ext_d  = s[M-1:0];
    if (s > SAT_POS) begin
      ext_d = SAT_POS[M-1:0];
    end else if (s < SAT_NEG) begin
      ext_d = SAT_NEG[M-1:0];
    end
  end

  // Stability counter next value; only consumed when a result is written.
  always_comb begin
    stable_next = '0;
    if (have_prev && (hard_d == hard_bit)) begin
      stable_next = (stable_count == COUNT_MAX) ? COUNT_MAX : stable_count + 1'b1;
    end
    conv_next = (stable_next >= THRESH_C);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ext_valid    <= 1'b0;
      extrinsic    <= '0;
      hard_bit     <= 1'b0;
      have_prev    <= 1'b0;
      stable_count <= '0;
      converged    <= 1'b0;
    end else if (frame_start) begin
      // Drop the in-flight result; extrinsic/hard_bit keep their last values.
      ext_valid    <= 1'b0;
      have_prev    <= 1'b0;
      stable_count <= '0;
      converged    <= 1'b0;
    end else begin
      ext_valid <= v1;
      if (v1) begin
        extrinsic    <= ext_d;
        hard_bit     <= hard_d;
        have_prev    <= 1'b1;
        stable_count <= stable_next;
        converged    <= conv_next;
      end
    end
  end

endmodule

// File: tb/tb_extrinsic_llr_pipe.sv
// Directed bench for extrinsic_llr_pipe: scaling/saturation vectors, stability counter,
// bubbles, frame_start flush and asynchronous reset.
module tb_extrinsic_llr_pipe;

  localparam int M      = 6;
  localparam int C      = 4;
  localparam int THRESH = 3;

  logic                   Clock = 1'b0;
  logic                   nReset;
  logic                   frame_start;
  logic                   in_valid;
  logic signed [4:1][M:0] epsilon;
  logic signed [M-1:0]    apriori;
  logic signed [M-1:0]    systematic;
  logic                   ext_valid;
  logic signed [M-1:0]    extrinsic;
  logic                   hard_bit;
  logic [C-1:0]           stable_count;
  logic                   converged;

  int checks = 0;
  int errors = 0;

  extrinsic_llr_pipe #(.M(M), .C(C), .THRESH(THRESH)) dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .frame_start  (frame_start),
    .in_valid     (in_valid),
    .epsilon      (epsilon),
    .apriori      (apriori),
    .systematic   (systematic),
    .ext_valid    (ext_valid),
    .extrinsic    (extrinsic),
    .hard_bit     (hard_bit),
    .stable_count (stable_count),
    .converged    (converged)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int e1, input int e2, input int e3, input int e4,
                       input int ap, input int sy);
    in_valid   = v;
    epsilon[1] = (M+1)'(e1);
    epsilon[2] = (M+1)'(e2);
    epsilon[3] = (M+1)'(e3);
    epsilon[4] = (M+1)'(e4);
    apriori    = M'(ap);
    systematic = M'(sy);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // Rising edge, then settle to the falling edge for sampling and driving.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic expect_out(input string tag, input int ev, input int ext, input int hb,
                            input int sc, input int cv);
    check({tag, ".ext_valid"}, int'(ext_valid), ev);
    check({tag, ".extrinsic"}, int'(extrinsic), ext);
    check({tag, ".hard_bit"}, int'(hard_bit), hb);
    check({tag, ".stable_count"}, int'(stable_count), sc);
    check({tag, ".converged"}, int'(converged), cv);
  endtask

  initial begin
    nReset      = 1'b0;
    frame_start = 1'b0;
    idle();
    #23;
    expect_out("reset", 0, 0, 0, 0, 0);
    @(negedge Clock);
    nReset = 1'b1;

    // Basic vector: d=9, e=6, s=5, post=14.
    drive(1'b1, 10, 4, -2, 1, 3, 5);
    tick();
    check("lat.early_valid", int'(ext_valid), 0);
    idle();
    tick();
    expect_out("basic", 1, 5, 1, 0, 0);

    // Positive saturation, negative saturation, floor shift; back-to-back.
    drive(1'b1, 63, 0, -64, -64, -32, 0);
    tick();
    drive(1'b1, -64, -64, 63, 0, 31, 0);
    tick();
    expect_out("satpos", 1, 31, 1, 1, 0);
    drive(1'b1, 0, -10, 5, 0, 0, 0);
    tick();
    expect_out("satneg", 1, -31, 0, 0, 0);
    idle();
    tick();
    expect_out("floor", 1, -3, 0, 1, 0);
    tick();
    expect_out("hold", 0, -3, 0, 1, 0);

    // New frame without data: counters clear, values retained.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    expect_out("fs_idle", 0, -3, 0, 0, 0);

    // Five hard_bit=1 results then one hard_bit=0 result.
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       drive(1'b1, 10, 4, -2, 1, 3, 5);
      else if (i == 5) drive(1'b1, 0, -10, 5, 0, 0, 0);
      else             idle();
      tick();
      if (i >= 1) begin
        if (i <= 5) begin
          check($sformatf("stab%0d.count", i - 1), int'(stable_count), i - 1);
          check($sformatf("stab%0d.conv", i - 1), int'(converged), (i - 1 >= THRESH) ? 1 : 0);
        end else begin
          check("stab_break.count", int'(stable_count), 0);
          check("stab_break.conv", int'(converged), 0);
          check("stab_break.hard", int'(hard_bit), 0);
        end
      end
    end

    // Twenty identical results after a 0: counts 0..15 then saturates.
    for (int i = 0; i < 21; i++) begin
      if (i < 20) drive(1'b1, 10, 4, -2, 1, 3, 5);
      else        idle();
      tick();
      if (i >= 1) begin
        check($sformatf("sat%0d.count", i - 1), int'(stable_count), (i - 1 > 15) ? 15 : i - 1);
      end
    end
    check("sat.conv", int'(converged), 1);
    tick();

    // Bubbles: in_valid 1,0,1,1 -> ext_valid 1,0,1,1 one tick later here.
    begin
      int exp_ev[6]  = '{0, 1, 0, 1, 1, 0};
      int exp_ext[6] = '{5, 5, 5, -31, -3, -3};
      for (int k = 0; k < 6; k++) begin
        case (k)
          0:       drive(1'b1, 10, 4, -2, 1, 3, 5);
          2:       drive(1'b1, -64, -64, 63, 0, 31, 0);
          3:       drive(1'b1, 0, -10, 5, 0, 0, 0);
          default: idle();
        endcase
        tick();
        check($sformatf("bub%0d.valid", k), int'(ext_valid), exp_ev[k]);
        check($sformatf("bub%0d.ext", k), int'(extrinsic), exp_ext[k]);
      end
    end

    // frame_start with a sample in stage 1 plus a simultaneous new sample.
    drive(1'b1, 63, 0, -64, -64, -32, 0);
    tick();
    drive(1'b1, 63, 0, -64, -64, -32, 0);
    tick();
    check("fs_pre.ext", int'(extrinsic), 31);
    frame_start = 1'b1;
    drive(1'b1, -64, -64, 63, 0, 31, 0);
    tick();
    frame_start = 1'b0;
    idle();
    expect_out("fs_drop", 0, 31, 1, 0, 0);
    tick();
    expect_out("fs_new", 1, -31, 0, 0, 0);
    tick();
    check("fs_after.valid", int'(ext_valid), 0);

    // Asynchronous reset mid-stream, then resume.
    drive(1'b1, 10, 4, -2, 1, 3, 5);
    tick();
    tick();
    check("pre_rst.valid", int'(ext_valid), 1);
    #1 nReset = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0, 0);
    idle();
    @(negedge Clock);
    nReset = 1'b1;
    drive(1'b1, 63, 0, -64, -64, -32, 0);
    tick();
    check("resume.early", int'(ext_valid), 0);
    idle();
    tick();
    expect_out("resume", 1, 31, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
